// File: rtl/tb_utils_pkg.sv
// Shared state encoding and defaults for the bench reset sequencer.
// No logic here, so no latency.
// No flow control: types, constants and one elaboration-time helper only.
package tb_utils_pkg;

    typedef enum logic [2:0] {
        RESET,
        HOLD,
        RUN,
        REQ,
        DONE,
        TOUT
    } rstgen_state_e;

    localparam int DEF_TIMEOUT = 100000;

    // Larger of two ints; used to size the shared hold/request down-counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tb_rst_sync.sv
// Async-assert / sync-deassert shift chain for the raw bench reset.
// Latency: rel rises STAGES clk edges after rst_n is released; falls immediately on rst_n low.
// No backpressure: free-running, re-arms only on the next rst_n assertion.
module tb_rst_sync #(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic rel
);

    logic [STAGES-1:0] chain;

    // Shift ones in after release; rst_n low clears every stage at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain[0] <= 1'b1;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign rel = chain[STAGES-1];

endmodule

// File: rtl/tb_rstgen.sv
// Bench reset sequencer: raw rst_n -> clean DUT reset, re-reset requests, run-cycle watchdog.
// Latency: dut_rst_n rises SYNC_STAGES+HOLD_CYCLES edges after release, REQ_CYCLES edges after req_reset.
// No backpressure: req_reset is a single-cycle pulse honoured only in RUN/DONE/TOUT, ignored elsewhere.
module tb_rstgen
    import tb_utils_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int REQ_CYCLES  = 4,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_reset,
    input  logic             dut_done,
    output logic             dut_rst_n,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             finished,
    output logic             timeout
);

    // Shared down-counter is sized for the longer of the two waits (at least one bit).
    localparam int            DMAX     = max2(max2(HOLD_CYCLES, REQ_CYCLES), 2);
    localparam int            DW       = $clog2(DMAX);
    localparam logic [DW-1:0] HOLD_LD  = DW'(max2(HOLD_CYCLES, 1) - 1);
    localparam logic [DW-1:0] REQ_LD   = DW'(REQ_CYCLES - 1);
    localparam logic [63:0]   TMO_LAST = 64'(TIMEOUT) - 64'd1;

    rstgen_state_e state, state_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic          rel;
    logic          cnt_inc;
    logic          clr_run;
    logic          fin_set;
    logic          tout_set;
    logic          tmo_hit;
    logic          cnt_sat;

    // The RESET->HOLD transition itself captures the last synchronizer stage, so the
    // chain holds one flop fewer and release-to-HOLD is exactly SYNC_STAGES edges.
    tb_rst_sync #(
        .STAGES (SYNC_STAGES - 1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rel   (rel)
    );

    assign tmo_hit = (TIMEOUT != 0) && (64'(cycle_cnt) == TMO_LAST);
    assign cnt_sat = &cycle_cnt;

    // Next-state decode; one down-counter serves both HOLD and REQ waits.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        cnt_inc   = 1'b0;
        clr_run   = 1'b0;
        fin_set   = 1'b0;
        tout_set  = 1'b0;
        case (state)
            RESET: begin
                if (rel) begin
                    if (HOLD_CYCLES == 0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = HOLD;
                        dcnt_nxt  = HOLD_LD;
                    end
                end
            end
            HOLD, REQ: begin
                if (dcnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    dcnt_nxt = dcnt - DW'(1);
                end
            end
            RUN: begin
                // req_reset outranks dut_done, which outranks the watchdog.
                if (req_reset) begin
                    state_nxt = REQ;
                    dcnt_nxt  = REQ_LD;
                    clr_run   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    if (dut_done) begin
                        state_nxt = DONE;
                        fin_set   = 1'b1;
                    end else if (tmo_hit) begin
                        state_nxt = TOUT;
                        tout_set  = 1'b1;
                    end
                end
            end
            DONE, TOUT: begin
                if (req_reset) begin
                    state_nxt = REQ;
                    dcnt_nxt  = REQ_LD;
                    clr_run   = 1'b1;
                end
            end
            default: begin
                state_nxt = RESET;
            end
        endcase
    end

    // State and outputs are registered from the next state, so dut_rst_n only rises on an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET;
            dcnt      <= '0;
            dut_rst_n <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_nxt;
            dcnt      <= dcnt_nxt;
            dut_rst_n <= (state_nxt == RUN) || (state_nxt == DONE) || (state_nxt == TOUT);
            running   <= (state_nxt == RUN);
        end
    end

    // Run-cycle counter saturates rather than wrapping; a re-reset zeroes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (clr_run) begin
            cycle_cnt <= '0;
        end else if (cnt_inc && !cnt_sat) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    // Sticky completion flags, cleared only by reset or a re-reset request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finished <= 1'b0;
            timeout  <= 1'b0;
        end else if (clr_run) begin
            finished <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (fin_set) begin
                finished <= 1'b1;
            end
            if (tout_set) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tb_rstgen.sv
// Self-checking bench for tb_rstgen: three configurations against a timestamp-based model.
// Outputs are compared every negedge; directed literal checks pin the model at key edges.
// Inputs are driven 2ns after posedge; random req/done/rst_n pulses follow the directed part.
module tb_tb_rstgen;

    localparam int NI = 3;
    // Instance 0: all defaults. 1: watchdog at 20. 2: 4-bit counter, no watchdog, no hold.
    localparam int P_SYNC [NI] = '{2, 4, 3};
    localparam int P_HOLD [NI] = '{8, 2, 0};
    localparam int P_REQ  [NI] = '{4, 2, 1};
    localparam int P_TMO  [NI] = '{100000, 20, 0};
    localparam int P_W    [NI] = '{32, 32, 4};

    logic          clk;
    logic          rst_n;
    logic [NI-1:0] req;
    logic [NI-1:0] done;
    logic          o_rstn [NI];
    logic          o_run  [NI];
    logic          o_fin  [NI];
    logic          o_tmo  [NI];
    logic [31:0]   o_cnt  [NI];
    logic [31:0]   cnt_a;
    logic [31:0]   cnt_b;
    logic [3:0]    cnt_c;

    int n_cmp = 0;
    int n_bad = 0;
    bit seen  = 1'b0;

    // Behavioural model: absolute edge number at which dut_rst_n is due to rise.
    bit     m_up   [NI];
    bit     m_run  [NI];
    bit     m_fin  [NI];
    bit     m_tmo  [NI];
    longint m_cnt  [NI];
    longint m_rise [NI];
    bit     m_wait;
    longint e_cnt;

    tb_rstgen u_a (
        .clk(clk), .rst_n(rst_n), .req_reset(req[0]), .dut_done(done[0]),
        .dut_rst_n(o_rstn[0]), .running(o_run[0]), .cycle_cnt(cnt_a),
        .finished(o_fin[0]), .timeout(o_tmo[0])
    );

    tb_rstgen #(
        .SYNC_STAGES(4), .HOLD_CYCLES(2), .REQ_CYCLES(2), .TIMEOUT(20), .CNT_W(32)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .req_reset(req[1]), .dut_done(done[1]),
        .dut_rst_n(o_rstn[1]), .running(o_run[1]), .cycle_cnt(cnt_b),
        .finished(o_fin[1]), .timeout(o_tmo[1])
    );

    tb_rstgen #(
        .SYNC_STAGES(3), .HOLD_CYCLES(0), .REQ_CYCLES(1), .TIMEOUT(0), .CNT_W(4)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .req_reset(req[2]), .dut_done(done[2]),
        .dut_rst_n(o_rstn[2]), .running(o_run[2]), .cycle_cnt(cnt_c),
        .finished(o_fin[2]), .timeout(o_tmo[2])
    );

    assign o_cnt[0] = cnt_a;
    assign o_cnt[1] = cnt_b;
    assign o_cnt[2] = {28'd0, cnt_c};

    // Clock: first posedge at 10ns, period 10ns.
    initial begin
        clk = 1'b0;
        #10;
        forever begin
            clk = 1'b1;
            #5;
            clk = 1'b0;
            #5;
        end
    end

    initial begin
        @(posedge clk);
        seen = 1'b1;
    end

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_up[i]   = 1'b0;
            m_run[i]  = 1'b0;
            m_fin[i]  = 1'b0;
            m_tmo[i]  = 1'b0;
            m_cnt[i]  = 0;
            m_rise[i] = -1;
        end
        m_wait = 1'b1;
    endtask

    task automatic model_edge();
        longint old;
        longint cmax;
        for (int i = 0; i < NI; i++) begin
            cmax = (longint'(1) << P_W[i]) - 1;
            if (m_wait) begin
                m_rise[i] = e_cnt + P_SYNC[i] + P_HOLD[i] - 1;
            end
            if (!m_up[i]) begin
                if (e_cnt == m_rise[i]) begin
                    m_up[i]  = 1'b1;
                    m_run[i] = 1'b1;
                end
            end else if (req[i]) begin
                m_up[i]   = 1'b0;
                m_run[i]  = 1'b0;
                m_rise[i] = e_cnt + P_REQ[i];
                m_cnt[i]  = 0;
                m_fin[i]  = 1'b0;
                m_tmo[i]  = 1'b0;
            end else if (m_run[i]) begin
                old = m_cnt[i];
                if (m_cnt[i] < cmax) m_cnt[i] = m_cnt[i] + 1;
                if (done[i]) begin
                    m_fin[i] = 1'b1;
                    m_run[i] = 1'b0;
                end else if (P_TMO[i] != 0 && old == P_TMO[i] - 1) begin
                    m_tmo[i] = 1'b1;
                    m_run[i] = 1'b0;
                end
            end
        end
        m_wait = 1'b0;
    endtask

    // Model update: async reset on rst_n low, otherwise one step per posedge.
    initial begin
        e_cnt = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (rst_n !== 1'b1) begin
                model_reset();
            end else begin
                e_cnt++;
                model_edge();
            end
        end
    end

    // Compare process: every negedge after the first clock edge, all outputs of all instances.
    initial begin
        forever begin
            @(negedge clk);
            if (seen) begin
                for (int i = 0; i < NI; i++) begin
                    n_cmp++;
                    if (o_rstn[i] !== m_up[i] || o_run[i] !== m_run[i] || o_fin[i] !== m_fin[i] ||
                        o_tmo[i] !== m_tmo[i] || o_cnt[i] !== 32'(m_cnt[i])) begin
                        n_bad++;
                        $display("FAIL cycle_check inst%0d t=%0t got rstn=%b run=%b fin=%b tmo=%b cnt=%0d want rstn=%b run=%b fin=%b tmo=%b cnt=%0d",
                                 i, $time, o_rstn[i], o_run[i], o_fin[i], o_tmo[i], o_cnt[i],
                                 m_up[i], m_run[i], m_fin[i], m_tmo[i], m_cnt[i]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_run(input int i, input int lim, input string name);
        int k = 0;
        while (o_run[i] !== 1'b1 && k < lim) begin
            step();
            k++;
        end
        chk(name, longint'(o_run[i]), 1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        req   = '0;
        done  = '0;

        // Reset values after the first edge with rst_n low.
        #15;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_rstn%0d", i), longint'(o_rstn[i]), 0);
            chk($sformatf("reset_run%0d", i), longint'(o_run[i]), 0);
            chk($sformatf("reset_cnt%0d", i), longint'(o_cnt[i]), 0);
            chk($sformatf("reset_fin%0d", i), longint'(o_fin[i]), 0);
            chk($sformatf("reset_tmo%0d", i), longint'(o_tmo[i]), 0);
        end

        // Power-up: release at 25ns, default instance rises on the 10th edge (120ns).
        #10;
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 9) chk("pwr_rstn_edge9", longint'(o_rstn[0]), 0);
            if (e == 10) begin
                chk("pwr_rstn_edge10", longint'(o_rstn[0]), 1);
                chk("pwr_run_edge10", longint'(o_run[0]), 1);
                chk("pwr_cnt_edge10", longint'(o_cnt[0]), 0);
            end
        end

        // Mid-hold 3ns reset pulse restarts the full sequence.
        rst_n = 1'b0;
        #5;
        rst_n = 1'b1;
        for (int e = 0; e < 4; e++) step();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        chk("midhold_rstn_low", longint'(o_rstn[0]), 0);
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 9) chk("midhold_rstn_edge9", longint'(o_rstn[0]), 0);
            if (e == 10) chk("midhold_rstn_edge10", longint'(o_rstn[0]), 1);
        end

        // req_reset pulse at cycle_cnt=50.
        k = 0;
        while (o_cnt[0] != 32'd50 && k < 200) begin
            step();
            k++;
        end
        chk("req_cnt_at_pulse", longint'(o_cnt[0]), 50);
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        chk("req_rstn_fall", longint'(o_rstn[0]), 0);
        chk("req_cnt_clear", longint'(o_cnt[0]), 0);
        step();
        step();
        step();
        chk("req_rstn_edge3", longint'(o_rstn[0]), 0);
        step();
        chk("req_rstn_edge4", longint'(o_rstn[0]), 1);
        chk("req_run_edge4", longint'(o_run[0]), 1);
        chk("req_cnt_edge4", longint'(o_cnt[0]), 0);

        // Same-edge dut_done and req_reset: request wins, finished stays low.
        step();
        step();
        step();
        done[0] = 1'b1;
        req[0]  = 1'b1;
        step();
        done[0] = 1'b0;
        req[0]  = 1'b0;
        chk("prio_fin_low", longint'(o_fin[0]), 0);
        chk("prio_rstn_low", longint'(o_rstn[0]), 0);
        wait_run(0, 10, "prio_back_to_run");
        done[0] = 1'b1;
        step();
        done[0] = 1'b0;
        chk("done_fin", longint'(o_fin[0]), 1);
        chk("done_run", longint'(o_run[0]), 0);
        chk("done_rstn_high", longint'(o_rstn[0]), 1);

        // Watchdog at 20 on instance 1 (already expired once, then re-run).
        chk("tout_prev_flag", longint'(o_tmo[1]), 1);
        chk("tout_prev_cnt", longint'(o_cnt[1]), 20);
        req[1] = 1'b1;
        step();
        req[1] = 1'b0;
        chk("tout_req_clear", longint'(o_tmo[1]), 0);
        wait_run(1, 10, "tout_back_to_run");
        for (int e = 0; e < 19; e++) step();
        chk("tout_cnt19", longint'(o_cnt[1]), 19);
        chk("tout_flag19", longint'(o_tmo[1]), 0);
        step();
        chk("tout_cnt20", longint'(o_cnt[1]), 20);
        chk("tout_flag20", longint'(o_tmo[1]), 1);
        chk("tout_run20", longint'(o_run[1]), 0);
        chk("tout_fin20", longint'(o_fin[1]), 0);

        // 4-bit counter with watchdog disabled saturates and keeps running.
        chk("sat_cnt", longint'(o_cnt[2]), 15);
        chk("sat_run", longint'(o_run[2]), 1);
        chk("sat_tmo", longint'(o_tmo[2]), 0);

        // Randomised phase: sparse req/done per instance, occasional async reset pulses.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                req[i]  = ($urandom_range(0, 49) == 0);
                done[i] = ($urandom_range(0, 79) == 0);
            end
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
            end
            step();
        end
        req  = '0;
        done = '0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
